// File: rtl/field_snapshot_tx_pkg.sv
// Shared definitions for the field snapshot transmitter.
//   SNAPSHOT_HDR     : first byte of every frame
//   snapshot_state_t : top-level sequencer states
//   fold_cksum       : running XOR checksum helper
package field_snapshot_tx_pkg;

    localparam logic [7:0] SNAPSHOT_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_CKSUM   = 3'd4,
        ST_DRAIN   = 3'd5
    } snapshot_state_t;

    function automatic logic [7:0] fold_cksum(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/field_snapshot_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one byte at a time.
//   i_valid/i_data : byte offered by the producer; taken when i_valid && o_ready
//   o_ready        : high while idle, and also during the last cycle of a stop
//                    bit so that the next byte can follow with no idle gap
//   o_tx           : registered serial line, idle high
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] B_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    logic          active_q, active_d;
    logic          tx_q, tx_d;
    logic [8:0]    sh_q, sh_d;      // remaining data bits with the stop bit on top
    logic [3:0]    bits_q, bits_d;  // bits still to send after the current one
    logic [BW-1:0] baud_q, baud_d;
    logic          bit_end_s;
    logic          ready_s;

    assign bit_end_s = active_q && (baud_q == B_LAST);
    assign ready_s   = !active_q || (bit_end_s && (bits_q == 4'd0));
    assign o_ready   = ready_s;
    assign o_tx      = tx_q;

    // Next-state logic: accept a byte, advance the baud counter, shift bits out.
    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        sh_d     = sh_q;
        bits_d   = bits_q;
        baud_d   = baud_q;
        if (i_valid && ready_s) begin
            // Start bit goes on the line at once; 8 data bits + stop remain.
            active_d = 1'b1;
            tx_d     = 1'b0;
            sh_d     = {1'b1, i_data};
            bits_d   = 4'd9;
            baud_d   = {BW{1'b0}};
        end else if (bit_end_s) begin
            baud_d = {BW{1'b0}};
            if (bits_q == 4'd0) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                tx_d   = sh_q[0];
                sh_d   = {1'b1, sh_q[8:1]};
                bits_d = bits_q - 4'd1;
            end
        end else if (active_q) begin
            baud_d = baud_q + B_ONE;
        end else begin
            tx_d = 1'b1;
        end
    end

    // Serialiser state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            sh_q     <= 9'h1FF;
            bits_q   <= 4'd0;
            baud_q   <= {BW{1'b0}};
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            sh_q     <= sh_d;
            bits_q   <= bits_d;
            baud_q   <= baud_d;
        end
    end

endmodule

// File: rtl/field_snapshot_tx.sv
// field_snapshot_tx: walks the Game-of-Life field RAM and sends it over UART
// as header 0xA5, FIELD_W*FIELD_H/8 row-major data bytes (LSB = lowest x),
// then the XOR of all data bytes.
//   i_go         : start request, only honoured while idle
//   i_cell_state : RAM data for the address presented on the previous cycle
//   o_cur_x/y    : RAM read address, zero while idle
//   o_busy       : high from accepting i_go until the frame has left the line
//   o_done       : one-cycle pulse as o_busy falls
//   o_uart_tx    : 8N1 serial output, idle high
module field_snapshot_tx
    import field_snapshot_tx_pkg::*;
#(
    parameter int FIELD_W      = 320,
    parameter int FIELD_H      = 240,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_go,
    input  logic                       i_cell_state,
    output logic [$clog2(FIELD_W)-1:0] o_cur_x,
    output logic [$clog2(FIELD_H)-1:0] o_cur_y,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_uart_tx
);

    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);
    localparam logic [XW-1:0] X_LAST = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FIELD_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    snapshot_state_t state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [3:0]      cnt_q, cnt_d;     // fetch slot 0..8; in DRAIN, "UART seen ready"
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      cksum_q, cksum_d;

    logic            uart_valid_s;
    logic [7:0]      uart_data_s;
    logic            uart_ready_s;
    logic            last_byte_s;

    assign last_byte_s = (x_q == X_LAST) && (y_q == Y_LAST);

    // Sequencer: next state, address walk, byte assembly and checksum.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        cksum_d      = cksum_q;
        uart_valid_s = 1'b0;
        uart_data_s  = SNAPSHOT_HDR;
        case (state_q)
            ST_IDLE: begin
                x_d = {XW{1'b0}};
                y_d = {YW{1'b0}};
                if (i_go) begin
                    state_d = ST_HEADER;
                    busy_d  = 1'b1;
                    cksum_d = 8'h00;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_HEADER: begin
                uart_valid_s = 1'b1;
                uart_data_s  = SNAPSHOT_HDR;
                if (uart_ready_s) begin
                    state_d = ST_FETCH;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_FETCH: begin
                // Slot n presents address x0+n (n<8); slot n+1 sees its data.
                if (cnt_q != 4'd0) begin
                    byte_d = {i_cell_state, byte_q[7:1]};
                end else begin
                    byte_d = byte_q;
                end
                // x stays on x0+7 after the last address; the row/byte step
                // happens only when the finished byte is handed over.
                if (cnt_q < 4'd7) begin
                    x_d = x_q + X_ONE;
                end else begin
                    x_d = x_q;
                end
                if (cnt_q == 4'd8) begin
                    state_d = ST_WAIT_TX;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WAIT_TX: begin
                uart_valid_s = 1'b1;
                uart_data_s  = byte_q;
                if (uart_ready_s) begin
                    cksum_d = fold_cksum(cksum_q, byte_q);
                    if (last_byte_s) begin
                        state_d = ST_CKSUM;
                    end else begin
                        state_d = ST_FETCH;
                        cnt_d   = 4'd0;
                        if (x_q == X_LAST) begin
                            x_d = {XW{1'b0}};
                            y_d = y_q + Y_ONE;
                        end else begin
                            x_d = x_q + X_ONE;
                        end
                    end
                end else begin
                    state_d = ST_WAIT_TX;
                end
            end
            ST_CKSUM: begin
                uart_valid_s = 1'b1;
                uart_data_s  = cksum_q;
                if (uart_ready_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_CKSUM;
                end
            end
            ST_DRAIN: begin
                // The UART reports ready already in the final stop-bit cycle,
                // so finish only on the second ready cycle: the line is idle.
                if (uart_ready_s && (cnt_q == 4'd1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    x_d     = {XW{1'b0}};
                    y_d     = {YW{1'b0}};
                end else if (uart_ready_s) begin
                    cnt_d = 4'd1;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                x_d     = {XW{1'b0}};
                y_d     = {YW{1'b0}};
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= {XW{1'b0}};
            y_q     <= {YW{1'b0}};
            cnt_q   <= 4'd0;
            byte_q  <= 8'h00;
            cksum_q <= 8'h00;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            cksum_q <= cksum_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(uart_valid_s),
        .i_data (uart_data_s),
        .o_ready(uart_ready_s),
        .o_tx   (o_uart_tx)
    );

    assign o_cur_x = x_q;
    assign o_cur_y = y_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
